// File: rtl/axi_bus_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// axi_bus_pkg: shared AXI burst/response encodings and arbiter state.
// Rev 1.0
// ------------------------------------------------------------------
package axi_bus_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_arb_state_t;

  // Width of an index into n masters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rr_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// axi_rr_arbiter: combinational round-robin pick, first request at or after ptr.
// Rev 1.0
// ------------------------------------------------------------------
module axi_rr_arbiter
  import axi_bus_pkg::*;
#(
  parameter int NUM_M = 2,
  localparam int IW   = idx_w(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [NUM_M-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic [NUM_M-1:0] rot;

  always_comb begin
    rot   = NUM_M'({req, req} >> ptr);
    valid = 1'b0;
    idx   = '0;
    grant = '0;
    // Scan from the far end so the candidate nearest the pointer wins last.
    for (int k = NUM_M - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % NUM_M);
      end
    end
    for (int j = 0; j < NUM_M; j++) begin
      grant[j] = valid && (idx == IW'(j));
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_wr_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// axi_wr_arbiter: round-robin share of one AXI write slave (AW/W/B) among NUM_M masters.
// Rev 1.0
// ------------------------------------------------------------------
module axi_wr_arbiter
  import axi_bus_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int ID_W  = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_M*ID_W-1:0] m_wr_addr_id,
  input  logic [NUM_M*AW-1:0]   m_wr_addr,
  input  logic [NUM_M*8-1:0]    m_wr_addr_len,
  input  logic [NUM_M*2-1:0]    m_wr_addr_burst,
  input  logic [NUM_M-1:0]      m_wr_addr_valid,
  output logic [NUM_M-1:0]      m_wr_addr_ready,
  input  logic [NUM_M*DW-1:0]   m_wr_data,
  input  logic [NUM_M*DW/8-1:0] m_wr_strb,
  input  logic [NUM_M-1:0]      m_wr_data_last,
  input  logic [NUM_M-1:0]      m_wr_data_valid,
  output logic [NUM_M-1:0]      m_wr_data_ready,
  output logic [NUM_M*ID_W-1:0] m_wr_back_id,
  output logic [NUM_M*2-1:0]    m_wr_back_resp,
  output logic [NUM_M-1:0]      m_wr_back_valid,
  input  logic [NUM_M-1:0]      m_wr_back_ready,
  output logic [ID_W-1:0]       s_wr_addr_id,
  output logic [AW-1:0]         s_wr_addr,
  output logic [7:0]            s_wr_addr_len,
  output logic [1:0]            s_wr_addr_burst,
  output logic                  s_wr_addr_valid,
  input  logic                  s_wr_addr_ready,
  output logic [DW-1:0]         s_wr_data,
  output logic [DW/8-1:0]       s_wr_strb,
  output logic                  s_wr_data_last,
  output logic                  s_wr_data_valid,
  input  logic                  s_wr_data_ready,
  input  logic [ID_W-1:0]       s_wr_back_id,
  input  logic [1:0]            s_wr_back_resp,
  input  logic                  s_wr_back_valid,
  output logic                  s_wr_back_ready,
  output logic [NUM_M-1:0]      grant,
  output logic                  len_err
);

  localparam int IW = idx_w(NUM_M);
  localparam int SW = DW / 8;

  wr_arb_state_t    state, state_nxt;
  logic [IW-1:0]    owner, ptr, arb_idx;
  logic [NUM_M-1:0] arb_grant;
  logic             arb_valid;
  logic [7:0]       len_q, beat;
  logic             aw_hs, w_hs, b_hs;

  logic [ID_W-1:0]  sel_id;
  logic [AW-1:0]    sel_addr;
  logic [7:0]       sel_len;
  logic [1:0]       sel_burst;
  logic             sel_aw_valid;
  logic [DW-1:0]    sel_data;
  logic [SW-1:0]    sel_strb;
  logic             sel_last, sel_w_valid, sel_b_ready;

  axi_rr_arbiter #(.NUM_M(NUM_M)) u_rr (
    .req   (m_wr_addr_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_id       = '0;
    sel_addr     = '0;
    sel_len      = '0;
    sel_burst    = '0;
    sel_aw_valid = 1'b0;
    sel_data     = '0;
    sel_strb     = '0;
    sel_last     = 1'b0;
    sel_w_valid  = 1'b0;
    sel_b_ready  = 1'b0;
    for (int j = 0; j < NUM_M; j++) begin
      if (owner == IW'(j)) begin
        sel_id       = m_wr_addr_id[j*ID_W +: ID_W];
        sel_addr     = m_wr_addr[j*AW +: AW];
        sel_len      = m_wr_addr_len[j*8 +: 8];
        sel_burst    = m_wr_addr_burst[j*2 +: 2];
        sel_aw_valid = m_wr_addr_valid[j];
        sel_data     = m_wr_data[j*DW +: DW];
        sel_strb     = m_wr_strb[j*SW +: SW];
        sel_last     = m_wr_data_last[j];
        sel_w_valid  = m_wr_data_valid[j];
        sel_b_ready  = m_wr_back_ready[j];
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    aw_hs           = 1'b0;
    w_hs            = 1'b0;
    b_hs            = 1'b0;
    s_wr_addr_id    = '0;
    s_wr_addr       = '0;
    s_wr_addr_len   = '0;
    s_wr_addr_burst = '0;
    s_wr_addr_valid = 1'b0;
    s_wr_data       = '0;
    s_wr_strb       = '0;
    s_wr_data_last  = 1'b0;
    s_wr_data_valid = 1'b0;
    s_wr_back_ready = 1'b0;
    m_wr_addr_ready = '0;
    m_wr_data_ready = '0;
    m_wr_back_id    = '0;
    m_wr_back_resp  = '0;
    m_wr_back_valid = '0;
    case (state)
      IDLE: if (arb_valid) state_nxt = ADDR;
      ADDR: begin
        s_wr_addr_id    = sel_id;
        s_wr_addr       = sel_addr;
        s_wr_addr_len   = sel_len;
        s_wr_addr_burst = sel_burst;
        s_wr_addr_valid = sel_aw_valid;
        m_wr_addr_ready = grant & {NUM_M{s_wr_addr_ready}};
        aw_hs           = sel_aw_valid & s_wr_addr_ready;
        if (aw_hs) state_nxt = DATA;
      end
      DATA: begin
        s_wr_data       = sel_data;
        s_wr_strb       = sel_strb;
        s_wr_data_last  = sel_last;
        s_wr_data_valid = sel_w_valid;
        m_wr_data_ready = grant & {NUM_M{s_wr_data_ready}};
        w_hs            = sel_w_valid & s_wr_data_ready;
        if (w_hs && sel_last) state_nxt = RESP;
      end
      RESP: begin
        s_wr_back_ready = sel_b_ready;
        m_wr_back_valid = grant & {NUM_M{s_wr_back_valid}};
        for (int j = 0; j < NUM_M; j++) begin
          if (grant[j]) begin
            m_wr_back_id[j*ID_W +: ID_W] = s_wr_back_id;
            m_wr_back_resp[j*2 +: 2]     = s_wr_back_resp;
          end
        end
        b_hs = s_wr_back_valid & sel_b_ready;
        if (b_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= '0;
      ptr     <= '0;
      grant   <= '0;
      len_q   <= '0;
      beat    <= '0;
      len_err <= 1'b0;
    end else begin
      if (state == IDLE && arb_valid) begin
        owner <= arb_idx;
        grant <= arb_grant;
      end
      if (aw_hs) begin
        len_q <= sel_len;
        beat  <= '0;
      end
      if (w_hs) begin
        beat <= beat + 8'd1;
        // LAST must coincide exactly with the final counted beat.
        if (sel_last != (beat == len_q)) len_err <= 1'b1;
      end
      if (b_hs) begin
        ptr   <= (owner == IW'(NUM_M - 1)) ? '0 : owner + IW'(1);
        grant <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_axi_wr_arbiter: table-driven write transactions with a W-beat scoreboard.
// Rev 1.0
// ------------------------------------------------------------------
module tb_axi_wr_arbiter;
  import axi_bus_pkg::*;

  localparam int NUM_M = 2;
  localparam int ID_W  = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;

  logic                  clk, rst;
  logic [NUM_M*ID_W-1:0] m_wr_addr_id;
  logic [NUM_M*AW-1:0]   m_wr_addr;
  logic [NUM_M*8-1:0]    m_wr_addr_len;
  logic [NUM_M*2-1:0]    m_wr_addr_burst;
  logic [NUM_M-1:0]      m_wr_addr_valid, m_wr_addr_ready;
  logic [NUM_M*DW-1:0]   m_wr_data;
  logic [NUM_M*SW-1:0]   m_wr_strb;
  logic [NUM_M-1:0]      m_wr_data_last, m_wr_data_valid, m_wr_data_ready;
  logic [NUM_M*ID_W-1:0] m_wr_back_id;
  logic [NUM_M*2-1:0]    m_wr_back_resp;
  logic [NUM_M-1:0]      m_wr_back_valid, m_wr_back_ready;
  logic [ID_W-1:0]       s_wr_addr_id;
  logic [AW-1:0]         s_wr_addr;
  logic [7:0]            s_wr_addr_len;
  logic [1:0]            s_wr_addr_burst;
  logic                  s_wr_addr_valid, s_wr_addr_ready;
  logic [DW-1:0]         s_wr_data;
  logic [SW-1:0]         s_wr_strb;
  logic                  s_wr_data_last, s_wr_data_valid, s_wr_data_ready;
  logic [ID_W-1:0]       s_wr_back_id;
  logic [1:0]            s_wr_back_resp;
  logic                  s_wr_back_valid, s_wr_back_ready;
  logic [NUM_M-1:0]      grant;
  logic                  len_err;

  axi_wr_arbiter #(.NUM_M(NUM_M), .ID_W(ID_W), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m_wr_addr_id(m_wr_addr_id), .m_wr_addr(m_wr_addr), .m_wr_addr_len(m_wr_addr_len),
    .m_wr_addr_burst(m_wr_addr_burst), .m_wr_addr_valid(m_wr_addr_valid),
    .m_wr_addr_ready(m_wr_addr_ready),
    .m_wr_data(m_wr_data), .m_wr_strb(m_wr_strb), .m_wr_data_last(m_wr_data_last),
    .m_wr_data_valid(m_wr_data_valid), .m_wr_data_ready(m_wr_data_ready),
    .m_wr_back_id(m_wr_back_id), .m_wr_back_resp(m_wr_back_resp),
    .m_wr_back_valid(m_wr_back_valid), .m_wr_back_ready(m_wr_back_ready),
    .s_wr_addr_id(s_wr_addr_id), .s_wr_addr(s_wr_addr), .s_wr_addr_len(s_wr_addr_len),
    .s_wr_addr_burst(s_wr_addr_burst), .s_wr_addr_valid(s_wr_addr_valid),
    .s_wr_addr_ready(s_wr_addr_ready),
    .s_wr_data(s_wr_data), .s_wr_strb(s_wr_strb), .s_wr_data_last(s_wr_data_last),
    .s_wr_data_valid(s_wr_data_valid), .s_wr_data_ready(s_wr_data_ready),
    .s_wr_back_id(s_wr_back_id), .s_wr_back_resp(s_wr_back_resp),
    .s_wr_back_valid(s_wr_back_valid), .s_wr_back_ready(s_wr_back_ready),
    .grant(grant), .len_err(len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int              m;
    logic [ID_W-1:0] id;
    logic [AW-1:0]   addr;
    logic [7:0]      len;
    logic [1:0]      burst;
    int              nbeats;
    int              last_at;
    int              stall_at;
    int              stall_len;
    logic [1:0]      resp;
    logic            exp_len_err;
  } txn_t;

  int vectors = 0;
  int errors  = 0;
  logic [DW+SW:0] sbq[$];

  function automatic txn_t mk(input int m, input logic [ID_W-1:0] id, input logic [AW-1:0] addr,
                              input logic [7:0] len, input logic [1:0] burst, input int nbeats,
                              input int last_at, input int stall_at, input int stall_len,
                              input logic [1:0] resp, input logic exp_len_err);
    txn_t t;
    t.m = m; t.id = id; t.addr = addr; t.len = len; t.burst = burst; t.nbeats = nbeats;
    t.last_at = last_at; t.stall_at = stall_at; t.stall_len = stall_len; t.resp = resp;
    t.exp_len_err = exp_len_err;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int m, input int b);
    return (DW'(m) << 16) | (DW'(32'hA0) + DW'(b));
  endfunction

  task automatic drive_aw(input txn_t t);
    m_wr_addr_id[t.m*ID_W +: ID_W] = t.id;
    m_wr_addr[t.m*AW +: AW]        = t.addr;
    m_wr_addr_len[t.m*8 +: 8]      = t.len;
    m_wr_addr_burst[t.m*2 +: 2]    = t.burst;
    m_wr_addr_valid[t.m]           = 1'b1;
  endtask

  task automatic drive_w(input int m, input int b, input logic last);
    m_wr_data[m*DW +: DW] = beat_data(m, b);
    m_wr_strb[m*SW +: SW] = (b % 2 == 1) ? SW'(4'h3) : {SW{1'b1}};
    m_wr_data_last[m]     = last;
    m_wr_data_valid[m]    = 1'b1;
  endtask

  task automatic run_txn(input txn_t t, output int wait_cyc);
    logic [NUM_M-1:0]      oh, bad;
    logic [NUM_M*ID_W-1:0] eid;
    logic [NUM_M*2-1:0]    eresp;
    logic [DW+SW:0]        exp;
    int b, guard, stall_left;
    logic pushed;
    oh = NUM_M'(1) << t.m;
    bad = '0;
    drive_aw(t);
    wait_cyc = 0;
    do begin
      @(negedge clk); #1;
      wait_cyc++;
    end while (!s_wr_addr_valid && wait_cyc < 20);
    chk("aw_fields", {s_wr_addr_valid, s_wr_addr_id, s_wr_addr, s_wr_addr_len, s_wr_addr_burst},
        {1'b1, t.id, t.addr, t.len, t.burst});
    chk("aw_grant", grant, oh);
    chk("aw_ready", m_wr_addr_ready, oh);
    @(negedge clk);
    m_wr_addr_valid[t.m] = 1'b0;
    b = 0; guard = 0; stall_left = t.stall_len; pushed = 1'b0;
    while (b < t.nbeats && guard < t.nbeats + t.stall_len + 20) begin
      guard++;
      drive_w(t.m, b, b == t.last_at);
      if (!pushed) begin
        sbq.push_back({m_wr_data[t.m*DW +: DW], m_wr_strb[t.m*SW +: SW], m_wr_data_last[t.m]});
        pushed = 1'b1;
      end
      if (b == t.stall_at && stall_left > 0) begin
        s_wr_data_ready = 1'b0;
        stall_left--;
      end else begin
        s_wr_data_ready = 1'b1;
      end
      #1;
      bad |= (m_wr_addr_ready | m_wr_data_ready | m_wr_back_valid) & ~oh;
      if (s_wr_data_valid && s_wr_data_ready) begin
        exp = sbq.pop_front();
        chk("w_beat", {s_wr_data, s_wr_strb, s_wr_data_last}, exp);
        b++;
        pushed = 1'b0;
      end else begin
        chk("w_hold", {s_wr_data_valid, s_wr_data, s_wr_strb, s_wr_data_last}, {1'b1, sbq[0]});
      end
      @(negedge clk);
    end
    chk("w_beat_count", 64'(b), 64'(t.nbeats));
    m_wr_data_valid[t.m] = 1'b0;
    m_wr_data_last[t.m]  = 1'b0;
    s_wr_data_ready      = 1'b1;
    sbq.delete();
    s_wr_back_id = t.id; s_wr_back_resp = t.resp; s_wr_back_valid = 1'b1;
    m_wr_back_ready[t.m] = 1'b1;
    #1;
    bad |= (m_wr_addr_ready | m_wr_data_ready | m_wr_back_valid) & ~oh;
    eid = '0;   eid[t.m*ID_W +: ID_W] = t.id;
    eresp = '0; eresp[t.m*2 +: 2] = t.resp;
    chk("b_route", {m_wr_back_valid, m_wr_back_id, m_wr_back_resp, s_wr_back_ready, s_wr_data_valid},
        {oh, eid, eresp, 1'b1, 1'b0});
    @(negedge clk);
    s_wr_back_valid = 1'b0;
    m_wr_back_ready[t.m] = 1'b0;
    #1;
    chk("grant_idle", grant, '0);
    chk("len_err", len_err, t.exp_len_err);
    chk("non_owner_quiet", bad, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t tbl[5];
    txn_t s0, s1, r0, r1;
    int w;
    rst = 1'b1;
    m_wr_addr_id = '0; m_wr_addr = '0; m_wr_addr_len = '0; m_wr_addr_burst = '0;
    m_wr_addr_valid = '0; m_wr_data = '0; m_wr_strb = '0; m_wr_data_last = '0;
    m_wr_data_valid = '0; m_wr_back_ready = '0;
    s_wr_addr_ready = 1'b1; s_wr_data_ready = 1'b1;
    s_wr_back_id = '0; s_wr_back_resp = '0; s_wr_back_valid = 1'b0;

    //        m  id     addr          len     burst       beats last stall len resp         err
    tbl[0] = mk(0, 2'd1, 32'h0000_0100, 8'd3,   BURST_INCR,  4,    3,   -1,   0, RESP_OKAY,   1'b0);
    tbl[1] = mk(1, 2'd2, 32'h0000_2000, 8'd7,   BURST_WRAP,  8,    7,    3,   3, RESP_SLVERR, 1'b0);
    tbl[2] = mk(0, 2'd3, 32'h0000_3000, 8'd0,   BURST_FIXED, 1,    0,   -1,   0, RESP_EXOKAY, 1'b0);
    tbl[3] = mk(0, 2'd0, 32'h0001_0000, 8'd255, BURST_INCR,  256,  255, 100,  2, RESP_OKAY,   1'b0);
    tbl[4] = mk(1, 2'd1, 32'h0000_5000, 8'd1,   BURST_INCR,  1,    0,   -1,   0, RESP_DECERR, 1'b1);
    s0     = mk(0, 2'd3, 32'h0000_0300, 8'd1,   BURST_INCR,  2,    1,   -1,   0, RESP_OKAY,   1'b1);
    s1     = mk(1, 2'd0, 32'h0000_0400, 8'd2,   BURST_INCR,  3,    2,   -1,   0, RESP_OKAY,   1'b1);
    r1     = mk(1, 2'd2, 32'h0000_0600, 8'd0,   BURST_INCR,  1,    0,   -1,   0, RESP_OKAY,   1'b0);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_grant", grant, '0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_s_valid", {s_wr_addr_valid, s_wr_data_valid, s_wr_back_ready}, '0);
    chk("rst_m_out", {m_wr_addr_ready, m_wr_data_ready, m_wr_back_valid}, '0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_txn(tbl[i], w);
      chk("grant_latency", 64'(w), 64'd1);
    end

    // Both masters request with the pointer at 0: M0 first, M1 after one idle cycle.
    drive_aw(s1);
    run_txn(s0, w);
    run_txn(s1, w);
    chk("rr_second_latency", 64'(w), 64'd1);
    run_txn(s0, w);
    // Pointer now 1: simultaneous request goes to M1.
    drive_aw(s0);
    run_txn(s1, w);
    run_txn(s0, w);

    // Abandon an 8-beat burst after two beats with an asynchronous reset.
    r0 = mk(0, 2'd1, 32'h0000_0500, 8'd7, BURST_INCR, 8, 7, -1, 0, RESP_OKAY, 1'b0);
    drive_aw(r0);
    w = 0;
    do begin @(negedge clk); #1; w++; end while (!s_wr_addr_valid && w < 20);
    chk("rst_case_aw", s_wr_addr, r0.addr);
    @(negedge clk);
    m_wr_addr_valid[0] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      drive_w(0, b, 1'b0);
      @(negedge clk);
    end
    drive_w(0, 2, 1'b0);
    #1;
    chk("mid_burst_valid", {s_wr_data_valid, s_wr_data}, {1'b1, beat_data(0, 2)});
    chk("len_err_sticky", len_err, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_grant", grant, '0);
    chk("async_rst_s_valid", {s_wr_addr_valid, s_wr_data_valid, s_wr_back_ready}, '0);
    chk("async_rst_s_payload", |{s_wr_addr_id, s_wr_addr, s_wr_addr_len, s_wr_addr_burst,
                                 s_wr_data, s_wr_strb, s_wr_data_last}, 1'b0);
    chk("async_rst_m_out", {m_wr_addr_ready, m_wr_data_ready, m_wr_back_valid}, '0);
    chk("async_rst_len_err", len_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_wr_data_valid = '0;
    m_wr_data_last  = '0;
    run_txn(r1, w);
    chk("post_rst_latency", 64'(w), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
